pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//   Generic inter-stage pipeline register for the pcpu core.
//   Successor to the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). Parametrised in payload and control width.
//   Uses a valid/ready handshake and a 2-entry skid buffer, so in_ready is fully registered.
//   Adds flush-to-bubble and a saturating stall counter, neither of which the fixed per-stage registers provide.
// PARAMETERS
//   DATA_W       128    payload width (PC, PC4, ALU result, Rs2 data, Rd addr, ...), opaque to this block
//   CTRL_W       8      control-field width (Branch, MemRW, RegWrite, MemtoReg, ...)
//   CTRL_BUBBLE  '0     control word emitted for a bubble; must encode "no side effects"
//   STALL_CNT_W  16     width of the saturating stall counter
// PORTS
//   clk_PipeReg      in   1            rising-edge clock
//   rst_n_PipeReg    in   1            asynchronous reset, active-low
//   flush_PipeReg    in   1            synchronous flush: drop all held entries
//   in_valid         in   1            upstream has a word
//   in_ready         out  1            registered; this block can accept a word
//   in_data          in   DATA_W       upstream payload
//   in_ctrl          in   CTRL_W       upstream control
//   out_valid        out  1            downstream word present
//   out_ready        in   1            downstream accepts
//   out_data         out  DATA_W       head payload
//   out_ctrl         out  CTRL_W       head control; CTRL_BUBBLE when out_valid=0
//   stall_cnt        out  STALL_CNT_W  cycles with out_valid & !out_ready, saturating
// BEHAVIOUR
//   Reset (async, rst_n_PipeReg=0):
//     state=EMPTY, in_ready=1, out_valid=0, out_data='0, out_ctrl=CTRL_BUBBLE, stall_cnt=0.
//     Reset mid-transfer discards all held entries.
//   Transfers:
//     push = in_valid & in_ready; pop = out_valid & out_ready; both evaluated on the same edge.
//   State machine (pcpu::pipe_state_t):
//     EMPTY : push             -> ONE   (word loaded into head)
//     ONE   : push & !pop      -> TWO   (word loaded into skid)
//             pop & !push      -> EMPTY
//             push & pop       -> ONE   (head replaced by incoming word)
//     TWO   : pop              -> ONE   (skid moves to head)
//             push impossible because in_ready=0
//   Registered flags:
//     in_ready <= (next_state != TWO)
//     out_valid = (state != EMPTY)
//   Ordering and latency:
//     Strict FIFO order.
//     Latency 1 cycle: a word pushed at edge N is visible at out_* after edge N.
//     Throughput: 1 word/cycle while out_ready=1.
//   Head and skid contents:
//     Head data holds while out_valid & !out_ready; no data is lost or duplicated.
//     Stale payload may remain in out_data when out_valid=0; out_ctrl is forced to CTRL_BUBBLE then.
//   Flush:
//     flush_PipeReg=1 at an edge -> state=EMPTY, in_ready=1, out_ctrl=CTRL_BUBBLE.
//     Flush wins over a simultaneous push; the incoming word is dropped.
//     A simultaneous pop still counts as consumed downstream; this block takes no further action.
//   stall_cnt:
//     Increments each edge with out_valid & !out_ready.
//     Saturates at all-ones; never wraps.
//     Unaffected by flush; cleared only by reset.
// CONFIGURATION
//   PIPE_REG_DEBUG_EN defined:
//     Ports debug_in_PipeReg / debug_out_PipeReg of type pcpu::Debug_t are added.
//     The debug word travels with its entry through head and skid with identical timing.
//     On each push with in_ctrl's MemRW bit set (bit index from pcpu::CTRL_MEMRW_BIT), the block calls
//       log_data("Mem","Address",in_data[31:0],debug_in_PipeReg).
//   PIPE_REG_DEBUG_EN undefined:
//     The debug ports, the debug storage and the logging are absent.
//     Datapath behaviour is identical in both builds.
// STRUCTURE
//   Package pcpu holds:
//     pipe_state_t enum {EMPTY, ONE, TWO}
//     CTRL_MEMRW_BIT
//     Debug_t and log_data, both already present
//   Sub-module pipe_slot:
//     One register entry (data, ctrl, optional debug) with load enable and async active-low reset.
//     Instantiated twice, as head and skid.
//   Control FSM and stall counter are written inline in pipe_stage_reg.
// TESTING
//   1. Reset, then in_valid=1 with data 0x11,0x22,0x33 on consecutive cycles, out_ready=1
//      -> out_data 0x11,0x22,0x33 one cycle later each; in_ready stays 1.
//   2. Push 0xA,0xB with out_ready=0
//      -> state TWO, in_ready=0; then out_ready=1 -> 0xA then 0xB, no loss.
//      stall_cnt counts the held cycles.
//   3. flush_PipeReg=1 with state TWO and in_valid=1 on the same edge
//      -> out_valid=0, out_ctrl=CTRL_BUBBLE, in_ready=1; the pushed word never appears.
//   4. Hold out_valid=1, out_ready=0 for 2^STALL_CNT_W+5 cycles (STALL_CNT_W=4)
//      -> stall_cnt stops at 4'hF.
//   5. Deassert rst_n_PipeReg between clock edges while in state ONE
//      -> all outputs at reset values immediately, before the next edge.
//   6. Random valid/ready stimulus, 10k cycles, scoreboard on every push/pop
//      -> output sequence equals input sequence; ctrl=CTRL_BUBBLE whenever out_valid=0.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared pcpu definitions for the pipeline-register slice.
// Holds the pipeline-register state encoding, the MemRW control bit position,
// the debug word type and the memory-access logging hook.
// The logging hook only exists when PIPE_REG_DEBUG_EN is defined.
package pcpu;

    // Occupancy of a pipeline register: no entry, head only, head plus skid
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_t;

    // Position of the MemRW flag inside the control word
    localparam int unsigned CTRL_MEMRW_BIT = 1;

    // Debug word carried alongside an instruction through the pipeline
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } Debug_t;

`ifdef PIPE_REG_DEBUG_EN
    // Logging hook; the simulation environment attaches its own sink here
    function automatic void log_data(input string unit_name, input string field_name,
                                     input logic [31:0] value, input Debug_t dbg);
    endfunction
`endif

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// pipe_slot: one pipeline-register entry (data, ctrl, optional debug word).
// Ports: clk_i, rst_ni (async active-low), load_i (capture inputs),
//        clr_ctrl_i (force ctrl to CTRL_BUBBLE, data kept), data_i/ctrl_i,
//        data_o/ctrl_o; debug_i/debug_o when PIPE_REG_DEBUG_EN is defined.
module pipe_slot
    import pcpu::*;
#(
    parameter int unsigned         DATA_W      = 128,
    parameter int unsigned         CTRL_W      = 8,
    parameter logic [CTRL_W-1:0]   CTRL_BUBBLE = '0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              clr_ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
`ifdef PIPE_REG_DEBUG_EN
    input  Debug_t            debug_i,
    output Debug_t            debug_o,
`endif
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o
);

    logic [DATA_W-1:0] data_q;
    logic [CTRL_W-1:0] ctrl_q;

    // Entry storage; a ctrl clear turns the entry into a bubble without touching data
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
            ctrl_q <= CTRL_BUBBLE;
        end else if (clr_ctrl_i) begin
            ctrl_q <= CTRL_BUBBLE;
        end else if (load_i) begin
            data_q <= data_i;
            ctrl_q <= ctrl_i;
        end
    end

    assign data_o = data_q;
    assign ctrl_o = ctrl_q;

`ifdef PIPE_REG_DEBUG_EN
    Debug_t debug_q;

    // Debug word follows the entry with identical load timing
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            debug_q <= '0;
        end else if (load_i && !clr_ctrl_i) begin
            debug_q <= debug_i;
        end
    end

    assign debug_o = debug_q;
`endif

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic valid/ready inter-stage pipeline register with a
// 2-entry skid buffer (head + skid), flush-to-bubble and a saturating stall counter.
// Ports: clk_PipeReg, rst_n_PipeReg (async active-low), flush_PipeReg,
//        in_valid/in_ready/in_data/in_ctrl (upstream), out_valid/out_ready/
//        out_data/out_ctrl (downstream), stall_cnt.
// Build option PIPE_REG_DEBUG_EN adds debug_in_PipeReg/debug_out_PipeReg and
// memory-access logging; datapath behaviour is the same in both builds.
module pipe_stage_reg
    import pcpu::*;
#(
    parameter int unsigned         DATA_W      = 128,
    parameter int unsigned         CTRL_W      = 8,
    parameter logic [CTRL_W-1:0]   CTRL_BUBBLE = '0,
    parameter int unsigned         STALL_CNT_W = 16
) (
    input  logic                   clk_PipeReg,
    input  logic                   rst_n_PipeReg,
    input  logic                   flush_PipeReg,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    input  logic [CTRL_W-1:0]      in_ctrl,
`ifdef PIPE_REG_DEBUG_EN
    input  Debug_t                 debug_in_PipeReg,
    output Debug_t                 debug_out_PipeReg,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [CTRL_W-1:0]      out_ctrl,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    pipe_state_t            state_q, state_d;
    logic                   in_ready_q;
    logic                   out_valid_q;
    logic [STALL_CNT_W-1:0] stall_q;

    logic                   push, pop;
    logic                   head_load, head_from_skid, head_clr, skid_load;
    logic [DATA_W-1:0]      skid_data, head_data_in;
    logic [CTRL_W-1:0]      skid_ctrl, head_ctrl_in;

    assign push = in_valid & in_ready_q;
    assign pop  = out_valid_q & out_ready;

    // Next state and slot steering; flush overrides everything and bubbles the head
    always_comb begin
        state_d        = state_q;
        head_load      = 1'b0;
        head_from_skid = 1'b0;
        head_clr       = 1'b0;
        skid_load      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d   = ONE;
                    head_load = 1'b1;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_load = 1'b1;
                end else if (push) begin
                    state_d   = TWO;
                    skid_load = 1'b1;
                end else if (pop) begin
                    state_d  = EMPTY;
                    head_clr = 1'b1;
                end
            end
            TWO: begin
                if (pop) begin
                    state_d        = ONE;
                    head_load      = 1'b1;
                    head_from_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush_PipeReg) begin
            state_d   = EMPTY;
            head_load = 1'b0;
            skid_load = 1'b0;
            head_clr  = 1'b1;
        end
    end

    // State and registered handshake flags
    always_ff @(posedge clk_PipeReg or negedge rst_n_PipeReg) begin
        if (!rst_n_PipeReg) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != TWO);
            out_valid_q <= (state_d != EMPTY);
        end
    end

    // Saturating stall counter, cleared only by reset
    always_ff @(posedge clk_PipeReg or negedge rst_n_PipeReg) begin
        if (!rst_n_PipeReg) begin
            stall_q <= '0;
        end else if (out_valid_q && !out_ready && (stall_q != '1)) begin
            stall_q <= stall_q + STALL_CNT_W'(1);
        end
    end

    // Head refills from the skid when draining TWO, otherwise from upstream
    assign head_data_in = head_from_skid ? skid_data : in_data;
    assign head_ctrl_in = head_from_skid ? skid_ctrl : in_ctrl;

`ifdef PIPE_REG_DEBUG_EN
    Debug_t skid_debug, head_debug_in;

    assign head_debug_in = head_from_skid ? skid_debug : debug_in_PipeReg;

    // Memory-access trace on every accepted word with MemRW set
    always_ff @(posedge clk_PipeReg) begin
        if (push && in_ctrl[CTRL_MEMRW_BIT]) begin
            log_data("Mem", "Address", in_data[31:0], debug_in_PipeReg);
        end
    end
`endif

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_BUBBLE(CTRL_BUBBLE)) u_head (
        .clk_i      (clk_PipeReg),
        .rst_ni     (rst_n_PipeReg),
        .load_i     (head_load),
        .clr_ctrl_i (head_clr),
        .data_i     (head_data_in),
        .ctrl_i     (head_ctrl_in),
`ifdef PIPE_REG_DEBUG_EN
        .debug_i    (head_debug_in),
        .debug_o    (debug_out_PipeReg),
`endif
        .data_o     (out_data),
        .ctrl_o     (out_ctrl)
    );

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_BUBBLE(CTRL_BUBBLE)) u_skid (
        .clk_i      (clk_PipeReg),
        .rst_ni     (rst_n_PipeReg),
        .load_i     (skid_load),
        .clr_ctrl_i (1'b0),
        .data_i     (in_data),
        .ctrl_i     (in_ctrl),
`ifdef PIPE_REG_DEBUG_EN
        .debug_i    (debug_in_PipeReg),
        .debug_o    (skid_debug),
`endif
        .data_o     (skid_data),
        .ctrl_o     (skid_ctrl)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: directed scenarios plus randomized valid/ready/flush
// traffic, all checked against a queue-based reference model of a 2-deep FIFO.
module tb_pipe_stage_reg;
    import pcpu::*;

    localparam int unsigned DW     = 32;
    localparam int unsigned CW     = 8;
    localparam int unsigned SW     = 4;
    localparam logic [CW-1:0] BUB  = 8'h5A;
    localparam logic [SW-1:0] SMAX = '1;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          in_valid, in_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_valid, out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [SW-1:0] stall_cnt;
`ifdef PIPE_REG_DEBUG_EN
    Debug_t        dbg_in, dbg_out;
    assign dbg_in = '0;
`endif

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_BUBBLE(BUB), .STALL_CNT_W(SW)) dut (
        .clk_PipeReg       (clk),
        .rst_n_PipeReg     (rst_n),
        .flush_PipeReg     (flush),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_data           (in_data),
        .in_ctrl           (in_ctrl),
`ifdef PIPE_REG_DEBUG_EN
        .debug_in_PipeReg  (dbg_in),
        .debug_out_PipeReg (dbg_out),
`endif
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .out_ctrl          (out_ctrl),
        .stall_cnt         (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } entry_t;

    entry_t        model_q[$];
    logic [SW-1:0] model_stall;
    int            n_cmp = 0;
    int            n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare every output against the model's current contents
    task automatic check_all();
        check_eq("in_ready", 64'(in_ready), 64'(model_q.size() < 2));
        check_eq("out_valid", 64'(out_valid), 64'(model_q.size() > 0));
        if (model_q.size() > 0) begin
            check_eq("out_data", 64'(out_data), 64'(model_q[0].d));
            check_eq("out_ctrl", 64'(out_ctrl), 64'(model_q[0].c));
        end else begin
            check_eq("out_ctrl_bubble", 64'(out_ctrl), 64'(BUB));
        end
        check_eq("stall_cnt", 64'(stall_cnt), 64'(model_stall));
    endtask

    // Drive one cycle (called at a negedge), advance the model, check after the edge
    task automatic step(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                        input logic r, input logic f);
        logic do_push, do_pop;
        entry_t e;
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = r;
        flush     = f;
        do_push = v && (model_q.size() < 2);
        do_pop  = (model_q.size() > 0) && r;
        if ((model_q.size() > 0) && !r && (model_stall != SMAX)) model_stall++;
        if (f) begin
            model_q.delete();
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) begin
                e.c = c;
                e.d = d;
                model_q.push_back(e);
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_q.delete();
        model_stall = '0;
    endtask

    initial begin
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0;
        model_stall = '0;
        @(negedge clk);
        do_reset();
        // Reset state
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_data", 64'(out_data), 64'd0);
        check_eq("rst_out_ctrl", 64'(out_ctrl), 64'(BUB));
        check_eq("rst_stall", 64'(stall_cnt), 64'd0);

        // Streaming at full rate
        step(1'b1, 32'h11, 8'h01, 1'b1, 1'b0);
        check_eq("t1_first", 64'(out_data), 64'h11);
        step(1'b1, 32'h22, 8'h02, 1'b1, 1'b0);
        check_eq("t1_second", 64'(out_data), 64'h22);
        step(1'b1, 32'h33, 8'h03, 1'b1, 1'b0);
        check_eq("t1_third", 64'(out_data), 64'h33);
        check_eq("t1_ready", 64'(in_ready), 64'd1);
        step(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);

        // Back-pressure fills the skid, then drains in order
        step(1'b1, 32'hA, 8'h0A, 1'b0, 1'b0);
        step(1'b1, 32'hB, 8'h0B, 1'b0, 1'b0);
        check_eq("t2_full_ready", 64'(in_ready), 64'd0);
        step(1'b1, 32'hC, 8'h0C, 1'b0, 1'b0);
        check_eq("t2_head_held", 64'(out_data), 64'hA);
        step(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
        check_eq("t2_then_b", 64'(out_data), 64'hB);
        step(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
        check_eq("t2_empty", 64'(out_valid), 64'd0);
        check_eq("t2_stall", 64'(stall_cnt), 64'd2);

        // Flush in TWO with a simultaneous push
        step(1'b1, 32'hD1, 8'hD1, 1'b0, 1'b0);
        step(1'b1, 32'hD2, 8'hD2, 1'b0, 1'b0);
        step(1'b1, 32'hD3, 8'hD3, 1'b0, 1'b1);
        check_eq("t3_valid", 64'(out_valid), 64'd0);
        check_eq("t3_ctrl", 64'(out_ctrl), 64'(BUB));
        check_eq("t3_ready", 64'(in_ready), 64'd1);
        step(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
        check_eq("t3_no_ghost", 64'(out_valid), 64'd0);

        // Stall counter saturation
        step(1'b1, 32'hE0, 8'hE0, 1'b0, 1'b0);
        for (int i = 0; i < (1 << SW) + 5; i++) step(1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
        check_eq("t4_saturated", 64'(stall_cnt), 64'hF);
        step(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);

        // Asynchronous reset between edges while holding one word
        step(1'b1, 32'h77, 8'h77, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t5_in_ready", 64'(in_ready), 64'd1);
        check_eq("t5_out_valid", 64'(out_valid), 64'd0);
        check_eq("t5_out_data", 64'(out_data), 64'd0);
        check_eq("t5_out_ctrl", 64'(out_ctrl), 64'(BUB));
        check_eq("t5_stall", 64'(stall_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_q.delete();
        model_stall = '0;
        check_all();

        // Randomized traffic against the model
        for (int i = 0; i < 10000; i++) begin
            step(($urandom % 4) != 0, DW'($urandom), CW'($urandom),
                 ($urandom % 3) != 0, ($urandom % 64) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
